// File: rtl/fft_twiddle_seq.sv
// ============================================================================
// Module  : fft_twiddle_seq
// Brief   : Radix-2 DIT FFT twiddle sequencer; walks stages/butterflies,
//           reads {cos,sin} from the twiddle RAM, hands them out via valid/ready.
//           Optional macro TW_REUSE_EN skips RAM reads when k repeats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_twiddle_seq #(
    parameter int LOG2N = 8,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic [AW-1:0]       ram_addr_o,
    input  logic [DW-1:0]       ram_data_i,
    output logic [2*DW-1:0]     tw_o,
    output logic                tw_valid_o,
    input  logic                tw_ready_i,
    output logic [3:0]          stage_o,
    output logic [LOG2N-2:0]    bfly_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int BW   = LOG2N - 1;
    localparam int BW1  = BW + 1;
    localparam int HALF = 1 << BW;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_COS = 3'd1,
        S_RD_SIN = 3'd2,
        S_OUT    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q;
    logic [3:0]         stage_q;
    logic [BW-1:0]      bfly_q;
    logic [2*DW-1:0]    tw_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;

    logic [3:0]         stage_d;
    logic [BW-1:0]      bfly_d;
    logic [BW-1:0]      k_cur;
    logic [BW-1:0]      k_d;
    logic               last_cur;
    logic               last_d;
    logic               reuse;

    // k = (b mod 2^s) << (LOG2N-1-s)
    function automatic logic [BW-1:0] tw_index(input logic [3:0] s, input logic [BW-1:0] b);
        logic [BW1-1:0] mask;
        mask = (BW1'(1) << s) - BW1'(1);
        return (b & mask[BW-1:0]) << (4'(BW) - s);
    endfunction

    function automatic logic is_last(input logic [3:0] s, input logic [BW-1:0] b);
        return (s == 4'(LOG2N - 1)) && (b == {BW{1'b1}});
    endfunction

    always_comb begin
        bfly_d   = bfly_q + BW'(1);
        stage_d  = (bfly_q == {BW{1'b1}}) ? stage_q + 4'd1 : stage_q;
        k_cur    = tw_index(stage_q, bfly_q);
        k_d      = tw_index(stage_d, bfly_d);
        last_cur = is_last(stage_q, bfly_q);
        last_d   = is_last(stage_d, bfly_d);
    end

`ifdef TW_REUSE_EN
    logic [BW-1:0]      held_k_q;
    logic               held_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_k_q   <= '0;
            held_vld_q <= 1'b0;
        end else if (state_q == S_IDLE && start_i) begin
            held_vld_q <= 1'b0;
        end else if (state_q == S_RD_SIN) begin
            held_k_q   <= k_cur;
            held_vld_q <= 1'b1;
        end
    end

    assign reuse = held_vld_q && (k_d == held_k_q);
`else
    assign reuse = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            tw_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RD_COS;
                        stage_q <= '0;
                        bfly_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RD_COS: begin
                    tw_q[2*DW-1:DW] <= ram_data_i;
                    state_q         <= S_RD_SIN;
                end
                S_RD_SIN: begin
                    tw_q[DW-1:0] <= ram_data_i;
                    state_q      <= S_OUT;
                    valid_q      <= 1'b1;
                    last_q       <= last_cur;
                end
                S_OUT: begin
                    if (tw_ready_i) begin
                        if (last_q) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stage_q <= stage_d;
                            bfly_q  <= bfly_d;
                            // A repeated k keeps tw_q and stays presenting
                            if (reuse) begin
                                last_q <= last_d;
                            end else begin
                                state_q <= S_RD_COS;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_addr_o = '0;
        case (state_q)
            S_RD_COS: ram_addr_o = AW'(k_cur);
            S_RD_SIN: ram_addr_o = AW'(HALF) + AW'(k_cur);
            default:  ram_addr_o = '0;
        endcase
    end

    assign tw_o       = tw_q;
    assign tw_valid_o = valid_q;
    assign stage_o    = stage_q;
    assign bfly_o     = bfly_q;
    assign last_o     = last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

`default_nettype wire
